// File: rtl/tx_frame_reader.sv
// TX frame reader: takes 3-beat descriptor commands, fetches the buffer over AXI read
// bursts and streams it byte-serially to the MAC, then returns a release response.
module tx_frame_reader #(
    parameter int DATA_RAM_DWORDS = 8192,
    parameter int MAX_BURST       = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] cmd_s_tdata,
    input  logic        cmd_s_tvalid,
    input  logic        cmd_s_tlast,
    output logic        cmd_s_tready,
    output logic [31:0] rsp_m_tdata,
    output logic        rsp_m_tvalid,
    output logic        rsp_m_tlast,
    input  logic        rsp_m_tready,
    output logic [3:0]  ram_m_arid,
    output logic [15:0] ram_m_araddr,
    output logic [7:0]  ram_m_arlen,
    output logic [2:0]  ram_m_arsize,
    output logic [1:0]  ram_m_arburst,
    output logic        ram_m_arvalid,
    input  logic        ram_m_arready,
    input  logic [3:0]  ram_m_rid,
    input  logic [31:0] ram_m_rdata,
    input  logic [1:0]  ram_m_rresp,
    input  logic        ram_m_rlast,
    input  logic        ram_m_rvalid,
    output logic        ram_m_rready,
    output logic [7:0]  mac_m_tdata,
    output logic        mac_m_tvalid,
    output logic        mac_m_tlast,
    input  logic        mac_m_tready
);
    localparam int AW = $clog2(DATA_RAM_DWORDS * 4);

    typedef enum logic [2:0] {S_CMD, S_CALC, S_AR, S_DATA, S_RESP} state_t;

    state_t        r_state;
    logic [1:0]    r_beat;
    logic          r_cmd_tready;
    logic [15:0]   r_len;
    logic [15:0]   r_addr;
    logic [31:0]   r_dw3_unused;
    logic          r_eop;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_rem;
    logic [AW-1:0] r_dw_rem;
    logic          r_ar_valid;
    logic [15:0]   r_araddr;
    logic [7:0]    r_arlen;
    logic          r_in_burst;
    logic [31:0]   r_hold;
    logic          r_hold_valid;
    logic [1:0]    r_idx;
    logic          r_first;
    logic          r_rsp_valid;

    logic          w_cmd_hs;
    logic          w_mac_hs;
    logic          w_last_in_word;
    logic          w_rready;
    logic          w_r_hs;
    logic [AW:0]   w_dw_sum;
    logic [AW-1:0] w_wrap_dw;
    logic [AW-1:0] w_burst;
    logic          w_unused;

    assign w_cmd_hs       = r_cmd_tready && cmd_s_tvalid;
    assign w_mac_hs       = r_hold_valid && mac_m_tready;
    // The word is used up either at lane 3 or when the descriptor's last byte goes out.
    assign w_last_in_word = (r_idx == 2'd3) || (r_rem == AW'(1));
    assign w_rready       = r_in_burst && (!r_hold_valid || (w_mac_hs && w_last_in_word));
    assign w_r_hs         = w_rready && ram_m_rvalid;
    assign w_dw_sum       = (AW+1)'(r_addr[1:0]) + (AW+1)'(r_len[AW-1:0]) + (AW+1)'(3);
    assign w_wrap_dw      = AW'(DATA_RAM_DWORDS) - AW'(r_cur[AW-1:2]);
    assign w_unused       = ^{ram_m_rid, ram_m_rresp, r_dw3_unused, w_dw_sum[1:0]};

    always_comb begin
        w_burst = r_dw_rem;
        if (w_burst > AW'(MAX_BURST)) w_burst = AW'(MAX_BURST);
        if (w_burst > w_wrap_dw)      w_burst = w_wrap_dw;
    end

    assign cmd_s_tready  = r_cmd_tready;
    assign rsp_m_tdata   = {r_len, r_addr};
    assign rsp_m_tvalid  = r_rsp_valid;
    assign rsp_m_tlast   = 1'b1;
    assign ram_m_arid    = 4'd0;
    assign ram_m_araddr  = r_araddr;
    assign ram_m_arlen   = r_arlen;
    assign ram_m_arsize  = 3'b010;
    assign ram_m_arburst = 2'b01;
    assign ram_m_arvalid = r_ar_valid;
    assign ram_m_rready  = w_rready;
    assign mac_m_tdata   = r_hold[{r_idx, 3'b000} +: 8];
    assign mac_m_tvalid  = r_hold_valid;
    assign mac_m_tlast   = r_hold_valid && r_eop && (r_rem == AW'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_CMD;
            r_beat       <= 2'd0;
            r_cmd_tready <= 1'b0;
            r_len        <= '0;
            r_addr       <= '0;
            r_dw3_unused <= '0;
            r_eop        <= 1'b0;
            r_cur        <= '0;
            r_rem        <= '0;
            r_dw_rem     <= '0;
            r_ar_valid   <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_in_burst   <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_idx        <= 2'd0;
            r_first      <= 1'b0;
            r_rsp_valid  <= 1'b0;
        end else begin
            // Byte lane runs independently of the FSM so it keeps draining across re-bursts.
            if (w_mac_hs) r_rem <= r_rem - AW'(1);
            if (w_r_hs) begin
                r_hold       <= ram_m_rdata;
                r_hold_valid <= 1'b1;
                r_idx        <= r_first ? r_addr[1:0] : 2'd0;
                r_first      <= 1'b0;
                if (ram_m_rlast) r_in_burst <= 1'b0;
            end else if (w_mac_hs) begin
                if (w_last_in_word) r_hold_valid <= 1'b0;
                else                r_idx        <= r_idx + 2'd1;
            end

            case (r_state)
                S_CMD: begin
                    r_cmd_tready <= 1'b1;
                    if (w_cmd_hs) begin
                        case (r_beat)
                            2'd0:    {r_len, r_addr} <= cmd_s_tdata;
                            2'd1:    r_eop <= cmd_s_tdata[24];
                            default: r_dw3_unused <= cmd_s_tdata;
                        endcase
                        if (r_beat == 2'd2) begin
                            r_beat       <= 2'd0;
                            r_cmd_tready <= 1'b0;
                            r_cur        <= r_addr[AW-1:0];
                            r_rem        <= r_len[AW-1:0];
                            r_dw_rem     <= AW'(w_dw_sum[AW:2]);
                            r_first      <= 1'b1;
                            r_state      <= S_CALC;
                        end else if (cmd_s_tlast) begin
                            r_beat <= 2'd0;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                S_CALC: begin
                    if (r_rem == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_araddr   <= 16'({r_cur[AW-1:2], 2'b00});
                        r_arlen    <= 8'(w_burst - AW'(1));
                        r_ar_valid <= 1'b1;
                        r_cur      <= {r_cur[AW-1:2] + w_burst[AW-3:0], 2'b00};
                        r_dw_rem   <= r_dw_rem - w_burst;
                        r_state    <= S_AR;
                    end
                end
                S_AR: begin
                    if (ram_m_arready) begin
                        r_ar_valid <= 1'b0;
                        r_in_burst <= 1'b1;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_r_hs && ram_m_rlast) begin
                        if (r_dw_rem != '0) r_state <= S_CALC;
                    end else if (!r_in_burst && r_dw_rem == '0 && w_mac_hs && r_rem == AW'(1)) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_m_tready) begin
                        r_rsp_valid  <= 1'b0;
                        r_cmd_tready <= 1'b1;
                        r_state      <= S_CMD;
                    end
                end
                default: r_state <= S_CMD;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_reader.sv
// Bench for tx_frame_reader: AXI RAM responder, descriptor-level expectation model,
// and a negedge monitor comparing every handshake against the model.
module tb_tx_frame_reader;
    localparam int AW        = 15;
    localparam int MEM_BYTES = 1 << AW;
    localparam int MEM_DW    = MEM_BYTES / 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] cmd_s_tdata = '0;
    logic        cmd_s_tvalid = 1'b0;
    logic        cmd_s_tlast = 1'b0;
    logic        cmd_s_tready;
    logic [31:0] rsp_m_tdata;
    logic        rsp_m_tvalid;
    logic        rsp_m_tlast;
    logic        rsp_m_tready = 1'b1;
    logic [3:0]  ram_m_arid;
    logic [15:0] ram_m_araddr;
    logic [7:0]  ram_m_arlen;
    logic [2:0]  ram_m_arsize;
    logic [1:0]  ram_m_arburst;
    logic        ram_m_arvalid;
    logic        ram_m_arready = 1'b0;
    logic [3:0]  ram_m_rid = '0;
    logic [31:0] ram_m_rdata = '0;
    logic [1:0]  ram_m_rresp = '0;
    logic        ram_m_rlast = 1'b0;
    logic        ram_m_rvalid = 1'b0;
    logic        ram_m_rready;
    logic [7:0]  mac_m_tdata;
    logic        mac_m_tvalid;
    logic        mac_m_tlast;
    logic        mac_m_tready = 1'b1;

    always #5 aclk = ~aclk;

    tx_frame_reader #(.DATA_RAM_DWORDS(8192), .MAX_BURST(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_s_tdata(cmd_s_tdata), .cmd_s_tvalid(cmd_s_tvalid), .cmd_s_tlast(cmd_s_tlast),
        .cmd_s_tready(cmd_s_tready),
        .rsp_m_tdata(rsp_m_tdata), .rsp_m_tvalid(rsp_m_tvalid), .rsp_m_tlast(rsp_m_tlast),
        .rsp_m_tready(rsp_m_tready),
        .ram_m_arid(ram_m_arid), .ram_m_araddr(ram_m_araddr), .ram_m_arlen(ram_m_arlen),
        .ram_m_arsize(ram_m_arsize), .ram_m_arburst(ram_m_arburst),
        .ram_m_arvalid(ram_m_arvalid), .ram_m_arready(ram_m_arready),
        .ram_m_rid(ram_m_rid), .ram_m_rdata(ram_m_rdata), .ram_m_rresp(ram_m_rresp),
        .ram_m_rlast(ram_m_rlast), .ram_m_rvalid(ram_m_rvalid), .ram_m_rready(ram_m_rready),
        .mac_m_tdata(mac_m_tdata), .mac_m_tvalid(mac_m_tvalid), .mac_m_tlast(mac_m_tlast),
        .mac_m_tready(mac_m_tready)
    );

    logic [7:0]  mem [MEM_BYTES];
    logic [8:0]  exp_bytes[$];
    logic [23:0] exp_ar[$];
    logic [31:0] exp_rsp[$];
    logic [7:0]  act_bytes[$];
    logic [23:0] act_ar[$];
    logic [31:0] act_rsp[$];
    int          act_last_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          bp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        int b;
        b = a & (MEM_BYTES - 4);
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    // Expected traffic for one descriptor, derived from byte range and burst limits.
    task automatic push_desc(input int len, input int addr, input bit eop);
        int dw, total, n;
        for (int k = 0; k < len; k++)
            exp_bytes.push_back({eop && (k == len - 1), mem[(addr + k) % MEM_BYTES]});
        if (len > 0) begin
            dw    = (addr % MEM_BYTES) / 4;
            total = ((addr % 4) + len + 3) / 4;
            while (total > 0) begin
                n = total;
                if (n > 16) n = 16;
                if (n > MEM_DW - dw) n = MEM_DW - dw;
                exp_ar.push_back({16'(dw * 4), 8'(n - 1)});
                dw    = (dw + n) % MEM_DW;
                total = total - n;
            end
        end
        exp_rsp.push_back({16'(len), 16'(addr)});
    endtask

    // AXI read responder: one burst at a time, back-to-back beats.
    logic [15:0] s_base, s_addr;
    logic [7:0]  s_len;
    int          s_beat, s_n;
    bit          s_active, s_ar_hs, s_r_hs;
    initial begin
        s_active = 0; s_beat = 0; s_n = 0; s_base = '0;
        forever begin
            @(negedge aclk);
            s_ar_hs = ram_m_arvalid && ram_m_arready;
            s_r_hs  = ram_m_rvalid && ram_m_rready;
            s_addr  = ram_m_araddr;
            s_len   = ram_m_arlen;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                s_active = 0;
            end else begin
                if (s_r_hs) begin
                    if (s_beat == s_n - 1) s_active = 0;
                    else s_beat++;
                end
                if (s_ar_hs) begin
                    s_base = s_addr; s_n = int'(s_len) + 1; s_beat = 0; s_active = 1;
                end
            end
            ram_m_arready = aresetn && !s_active;
            ram_m_rvalid  = s_active;
            ram_m_rdata   = mem_word(int'(s_base) + 4 * s_beat);
            ram_m_rlast   = s_active && (s_beat == s_n - 1);
        end
    end

    // Sink ready patterns: MAC 1-0-0-1 when backpressure is on; response ready 2 of 3 cycles.
    initial begin
        int bp_i, rsp_i;
        logic [3:0] bp_pat;
        bp_pat = 4'b1001;
        bp_i = 0; rsp_i = 0;
        forever begin
            @(posedge aclk);
            #1;
            mac_m_tready = bp_en ? bp_pat[bp_i % 4] : 1'b1;
            rsp_m_tready = (rsp_i % 3) != 1;
            bp_i++; rsp_i++;
        end
    end

    bit         prev_stall = 0;
    logic [8:0] prev_out;
    always @(negedge aclk) begin
        logic [8:0] eb;
        if (!aresetn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("mac_hold", {mac_m_tvalid, mac_m_tlast, mac_m_tdata}, {1'b1, prev_out});
            if (mac_m_tvalid && !mac_m_tready)
                check("rready_stall", ram_m_rready, 1'b0);
            prev_stall = mac_m_tvalid && !mac_m_tready;
            prev_out   = {mac_m_tlast, mac_m_tdata};
            if (mac_m_tvalid && mac_m_tready) begin
                act_bytes.push_back(mac_m_tdata);
                if (mac_m_tlast) act_last_cnt++;
                if (exp_bytes.size() == 0) check("mac_extra", {mac_m_tlast, mac_m_tdata}, 64'h1_0000);
                else begin
                    eb = exp_bytes.pop_front();
                    check("mac_byte", {mac_m_tlast, mac_m_tdata}, eb);
                end
            end
            if (ram_m_arvalid && ram_m_arready) begin
                act_ar.push_back({ram_m_araddr, ram_m_arlen});
                if (exp_ar.size() == 0) check("ar_extra", {ram_m_araddr, ram_m_arlen}, 64'h1_0000_00);
                else check("ar", {ram_m_arid, ram_m_arsize, ram_m_arburst, ram_m_araddr, ram_m_arlen},
                           {4'd0, 3'b010, 2'b01, exp_ar.pop_front()});
            end
            if (rsp_m_tvalid && rsp_m_tready) begin
                act_rsp.push_back(rsp_m_tdata);
                if (exp_rsp.size() == 0) check("rsp_extra", rsp_m_tdata, 64'h1_0000_0000);
                else check("rsp", {rsp_m_tlast, rsp_m_tdata}, {1'b1, exp_rsp.pop_front()});
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last);
        bit got;
        int waited;
        cmd_s_tdata = d; cmd_s_tlast = last; cmd_s_tvalid = 1'b1;
        got = 0; waited = 0;
        while (!got && waited < 1000) begin
            @(negedge aclk);
            got = cmd_s_tready;
            waited++;
        end
        check("cmd_accept", got, 1'b1);
        @(posedge aclk);
        #1;
        cmd_s_tvalid = 1'b0; cmd_s_tlast = 1'b0;
    endtask

    task automatic send_desc(input int len, input int addr, input bit eop, input bit malformed);
        send_beat({16'(len), 16'(addr)}, 1'b0);
        send_beat({7'd0, eop, 24'h00_0000}, malformed);
        if (!malformed) send_beat(32'hDEAD_BEEF, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int waited;
        waited = 0;
        while ((exp_bytes.size() + exp_ar.size() + exp_rsp.size()) != 0 && waited < 3000) begin
            @(negedge aclk);
            waited++;
        end
        repeat (6) @(negedge aclk);
        check(name, exp_bytes.size() + exp_ar.size() + exp_rsp.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_logs();
        act_bytes.delete(); act_ar.delete(); act_rsp.delete(); act_last_cnt = 0;
    endtask

    function automatic logic [23:0] ar_at(input int i);
        return (act_ar.size() > i) ? act_ar[i] : 24'hFFFFFF;
    endfunction
    function automatic logic [7:0] byte_at(input int i);
        return (act_bytes.size() > i) ? act_bytes[i] : 8'hXX;
    endfunction
    function automatic logic [31:0] rsp_at(input int i);
        return (act_rsp.size() > i) ? act_rsp[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [15:0] reset_vec();
        return {cmd_s_tready, ram_m_arvalid, ram_m_rready, mac_m_tvalid, mac_m_tlast, rsp_m_tvalid,
                ram_m_arsize, ram_m_arburst, ram_m_arid, rsp_m_tlast};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs", reset_vec(), {6'b0, 3'b010, 2'b01, 4'h0, 1'b1});
        aresetn = 1'b1;
        @(negedge aclk);
        check("tready_after_release_0", cmd_s_tready, 1'b0);
        @(negedge aclk);
        check("tready_after_release_1", cmd_s_tready, 1'b1);
        @(posedge aclk);
        #1;

        // Aligned single frame
        clear_logs();
        push_desc(8, 16'h0000, 1'b1);
        send_desc(8, 16'h0000, 1'b1, 1'b0);
        wait_done("t1_done");
        $display("t1 aligned: %0d bytes, %0d ARs", act_bytes.size(), act_ar.size());
        check("t1_ar", ar_at(0), {16'h0000, 8'd1});
        check("t1_first", byte_at(0), 8'h00);
        check("t1_last", byte_at(7), 8'h07);
        check("t1_rsp", rsp_at(0), 32'h0008_0000);

        // Unaligned start with trailing discard
        clear_logs();
        push_desc(6, 16'h0003, 1'b1);
        send_desc(6, 16'h0003, 1'b1, 1'b0);
        wait_done("t2_done");
        $display("t2 unaligned: %0d bytes, %0d ARs", act_bytes.size(), act_ar.size());
        check("t2_ar", ar_at(0), {16'h0000, 8'd2});
        check("t2_first", byte_at(0), 8'h03);
        check("t2_last", byte_at(5), 8'h08);
        check("t2_nbytes", act_bytes.size(), 6);

        // Address wrap at the top of the data RAM
        clear_logs();
        push_desc(8, 16'h7FFE, 1'b1);
        send_desc(8, 16'h7FFE, 1'b1, 1'b0);
        wait_done("t3_done");
        $display("t3 wrap: %0d bytes, %0d ARs", act_bytes.size(), act_ar.size());
        check("t3_ar0", ar_at(0), {16'h7FFC, 8'd0});
        check("t3_ar1", ar_at(1), {16'h0000, 8'd1});
        check("t3_byte0", byte_at(0), 8'h81);
        check("t3_byte2", byte_at(2), 8'h00);
        check("t3_rsp", rsp_at(0), 32'h0008_7FFE);

        // Burst split, then a second descriptor closing the frame
        clear_logs();
        push_desc(100, 16'h0100, 1'b0);
        send_desc(100, 16'h0100, 1'b0, 1'b0);
        push_desc(4, 16'h0400, 1'b1);
        send_desc(4, 16'h0400, 1'b1, 1'b0);
        wait_done("t4_done");
        $display("t4 split: %0d bytes, %0d ARs, %0d tlast", act_bytes.size(), act_ar.size(), act_last_cnt);
        check("t4_ar0", ar_at(0), {16'h0100, 8'd15});
        check("t4_ar1", ar_at(1), {16'h0140, 8'd8});
        check("t4_ar2", ar_at(2), {16'h0400, 8'd0});
        check("t4_rsp0", rsp_at(0), 32'h0064_0100);
        check("t4_rsp1", rsp_at(1), 32'h0004_0400);
        check("t4_tlast_cnt", act_last_cnt, 1);

        // MAC backpressure
        clear_logs();
        bp_en = 1'b1;
        push_desc(12, 16'h0200, 1'b1);
        send_desc(12, 16'h0200, 1'b1, 1'b0);
        wait_done("t5_done");
        bp_en = 1'b0;
        $display("t5 backpressure: %0d bytes", act_bytes.size());
        check("t5_nbytes", act_bytes.size(), 12);

        // Zero-length descriptor
        clear_logs();
        push_desc(0, 16'h0010, 1'b1);
        send_desc(0, 16'h0010, 1'b1, 1'b0);
        wait_done("t6_done");
        $display("t6 zero length: %0d ARs", act_ar.size());
        check("t6_no_ar", act_ar.size(), 0);
        check("t6_rsp", rsp_at(0), 32'h0000_0010);

        // Malformed command followed by a good one
        clear_logs();
        send_desc(8, 16'h0020, 1'b1, 1'b1);
        push_desc(4, 16'h0030, 1'b1);
        send_desc(4, 16'h0030, 1'b1, 1'b0);
        wait_done("t7_done");
        $display("t7 malformed: %0d ARs, %0d responses", act_ar.size(), act_rsp.size());
        check("t7_ar_cnt", act_ar.size(), 1);
        check("t7_ar", ar_at(0), {16'h0030, 8'd0});
        check("t7_rsp_cnt", act_rsp.size(), 1);

        // Reset mid-burst, then a fresh command
        clear_logs();
        push_desc(64, 16'h0800, 1'b1);
        send_desc(64, 16'h0800, 1'b1, 1'b0);
        waited = 0;
        while (act_bytes.size() < 5 && waited < 500) begin
            @(posedge aclk);
            waited++;
        end
        check("t8_started", act_bytes.size() >= 5, 1'b1);
        #1;
        aresetn = 1'b0;
        #1;
        check("t8_reset_outputs", reset_vec(), {6'b0, 3'b010, 2'b01, 4'h0, 1'b1});
        exp_bytes.delete(); exp_ar.delete(); exp_rsp.delete();
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("t8_tready_low", cmd_s_tready, 1'b0);
        @(posedge aclk);
        #1;
        clear_logs();
        push_desc(8, 16'h0040, 1'b1);
        send_desc(8, 16'h0040, 1'b1, 1'b0);
        wait_done("t8_done");
        $display("t8 reset recovery: %0d bytes, %0d responses", act_bytes.size(), act_rsp.size());
        check("t8_ar", ar_at(0), {16'h0040, 8'd1});
        check("t8_rsp", rsp_at(0), 32'h0008_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tx_frame_reader.md
Name: tx_frame_reader

Overview:
- Frame-process stage directly downstream of the TX descriptor engine.
- Accepts 3-beat per-descriptor commands ({length, local byte address}, DESC_DW2, DESC_DW3), reads the buffer bytes from the shared data RAM over an AXI read channel and streams them byte-serially to the MAC.
- Asserts tlast on the final byte of an EOP descriptor.
- Returns a release response {length, address} so the descriptor engine can reclaim data-RAM space.

Parameters:
- DATA_RAM_DWORDS, 8192: data RAM size in dwords. Byte address width AW = clog2(DATA_RAM_DWORDS*4), which is 15 at the default.
- MAX_BURST, 16: maximum dwords per AXI read burst (power of two, at most 256).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- cmd_s_tdata  in  32  beat0 {[31:16] len, [15:0] addr}; beat1 DW2; beat2 DW3
- cmd_s_tvalid  in  1  command valid
- cmd_s_tlast  in  1  high on beat2
- cmd_s_tready  out  1  command ready
- rsp_m_tdata  out  32  {[31:16] len, [15:0] addr} echoed from beat0
- rsp_m_tvalid  out  1  response valid
- rsp_m_tlast  out  1  constant 1
- rsp_m_tready  in  1  response ready
- ram_m_arid  out  4  constant 0
- ram_m_araddr  out  16  dword-aligned byte address
- ram_m_arlen  out  8  burst dwords minus 1
- ram_m_arsize  out  3  constant 3'b010
- ram_m_arburst  out  2  constant INCR
- ram_m_arvalid  out  1  address valid
- ram_m_arready  in  1  address ready
- ram_m_rid  in  4  ignored
- ram_m_rdata  in  32  read data, little-endian
- ram_m_rresp  in  2  ignored
- ram_m_rlast  in  1  last beat of burst
- ram_m_rvalid  in  1  read data valid
- ram_m_rready  out  1  read data ready
- mac_m_tdata  out  8  frame byte
- mac_m_tvalid  out  1  byte valid
- mac_m_tlast  out  1  last byte of frame
- mac_m_tready  in  1  MAC ready

Behaviour:
- Clock, reset and reset values:
  - Clock aclk. Reset aresetn, asynchronous, active-low.
  - Reset clears: FSM to S_CMD with beat counter 0; cmd_s_tready, ram_m_arvalid, ram_m_rready, mac_m_tvalid, mac_m_tlast, rsp_m_tvalid all 0; arsize 3'b010, arburst 2'b01, arid 0, rsp_m_tlast 1.
  - cmd_s_tready rises one cycle after reset release.
- Reset mid-operation: abandons any burst or partial frame immediately with no response. Outstanding R beats after reset are the interconnect's concern.
- Command decode:
  - EOP = DW2[24]. DW3 is latched but unused.
  - In S_CMD, cmd_s_tready=1 and the beat counter (0..2) advances on each handshake.
  - Beat counter resets to 0 when tlast is seen. A tlast on beat 0 or 1 is a malformed command: discarded, no data, no response.
  - After beat2 is accepted, cmd_s_tready drops on the next edge and the FSM enters S_CALC.
- Address and length arithmetic, both AW-bit and wrapping modulo 2^AW:
  - cur = addr; rem = len; off = addr[1:0].
  - Dwords needed = (off + len + 3) >> 2.
- S_CALC (1 cycle):
  - len = 0: go straight to S_RESP.
  - Otherwise burst = min(remaining dwords, MAX_BURST, dwords before the 2^AW wrap). Set araddr = {cur[AW-1:2], 2'b00} zero-extended to 16 bits, arlen = burst-1, arvalid=1, then S_AR.
- S_AR: hold until arready; then arvalid=0 and go to S_DATA.
- S_DATA:
  - One 32-bit holding register plus byte index; the first word's index starts at off, later words at 0.
  - rready = !hold_valid || (mac handshake on byte index 3 this cycle), giving 1 byte/cycle sustained.
  - Bytes emitted little-endian; each MAC handshake decrements rem.
  - Bytes past rem in the final word are discarded.
  - On rlast accept with dwords still remaining, go back to S_CALC with cur advanced.
  - When rem reaches 0 and the last byte is accepted, go to S_RESP.
- mac_m_tlast = 1 only with the final byte of a descriptor whose EOP=1. Non-EOP descriptors continue the same frame with no gap requirement.
- S_RESP: rsp_m_tvalid=1 with the latched {len, addr}; on rsp_m_tready, return to S_CMD.
- Simultaneous events:
  - The command port is not re-opened before the response handshake, so only one descriptor is in flight.
  - Output holds stable while mac_m_tready=0. An R beat arriving while the holding register is full and not draining is stalled by rready=0.

Test Plan:
- Aligned single frame: cmd {len=8, addr=0x0000}, DW2=0x01000000; RAM words 0x03020100, 0x07060504 -> one AR (addr 0x0000, arlen 1); bytes 00..07; tlast on 07; response 0x00080000.
- Unaligned: {len=6, addr=0x0003}, EOP -> AR addr 0x0000, arlen 2; bytes from RAM offsets 3..8; first word bytes 0-2 and trailing bytes dropped; tlast on 6th byte.
- Wrap: AW=15, {len=8, addr=0x7FFE} -> bursts (0x7FFC, arlen 0), (0x0000, arlen 1); 8 bytes in order; response echoes 0x00087FFE.
- Burst split plus two-descriptor frame: desc A {len=100, addr=0x0100} non-EOP, then desc B {len=4} EOP -> A issues arlen 15 then 8; no tlast within A; two responses in order; tlast only on B's last byte.
- MAC backpressure: toggle mac_m_tready 1-0-0-1 during len=12 -> no byte lost or duplicated; rready deasserts while the holding register is full.
- Malformed and reset: tlast on beat1 -> no AR, no response, next good command processed. Assert aresetn low mid-burst -> all outputs at reset values next cycle, a fresh command completes.
